// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, board size, CPU move priority and
// the move-selector FSM state encoding.
package ttt_pkg;

  localparam logic [1:0] CellPlayer = 2'd0;
  localparam logic [1:0] CellCpu    = 2'd1;
  localparam logic [1:0] CellEmpty  = 2'd2;

  localparam int unsigned N_CELLS = 9;

  // Centre first, then corners, then edges.
  localparam logic [3:0] CPU_PRIO [N_CELLS] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  typedef enum logic [2:0] {
    StIdle,
    StPlayer,
    StCpuWait,
    StCpuScan,
    StIssue,
    StSettle
  } state_e;

  // Code 3 is not EMPTY, so it reads as occupied.
  function automatic logic cell_empty(logic [17:0] board, logic [3:0] idx);
    logic [4:0] lsb;
    lsb = {idx, 1'b0};
    return board[lsb +: 2] == CellEmpty;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop synchronizer -> stability counter -> one-cycle press pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic [1:0]      sync_q;
  logic [1:0]      fill_q;
  logic            cand_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            known_q;
  logic            level_q;
  logic            press_q;
  logic            accept;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_q[1] != cand_q) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The first accepted level after reset only primes the detector, so a button
  // held through reset must be released and pressed again to register.
  assign accept = fill_q[1] && (cnt_d == CntMax) && (!known_q || (level_q != sync_q[1]));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      fill_q  <= '0;
      cand_q  <= 1'b0;
      cnt_q   <= '0;
      known_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      fill_q  <= {fill_q[0], 1'b1};
      press_q <= 1'b0;
      if (fill_q[1]) begin
        cand_q <= sync_q[1];
        cnt_q  <= cnt_d;
        if (accept) begin
          known_q <= 1'b1;
          level_q <= sync_q[1];
          press_q <= known_q && sync_q[1];
        end
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/move_selector.sv
// Move source for the game core: player cursor/confirm and CPU priority scan,
// issuing one validated cell per turn over a valid/ack handshake.
module move_selector
  import ttt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CPU_DELAY       = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_confirm,
  input  logic [17:0] board,
  input  logic        turn,
  input  logic        game_over,
  input  logic        move_ack,
  output logic [3:0]  cursor,
  output logic [3:0]  move_pos,
  output logic        move_valid,
  output logic        reject
);

  localparam int unsigned DlyW = $clog2(CPU_DELAY + 1);
  localparam logic [DlyW-1:0] DlyLast = DlyW'(CPU_DELAY - 1);
  localparam logic [3:0] LastCell = 4'(N_CELLS - 1);

  logic left_p, right_p, confirm_p;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk_i   (clock),
    .rst_i   (reset),
    .btn_i   (btn_left),
    .press_o (left_p)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk_i   (clock),
    .rst_i   (reset),
    .btn_i   (btn_right),
    .press_o (right_p)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
    .clk_i   (clock),
    .rst_i   (reset),
    .btn_i   (btn_confirm),
    .press_o (confirm_p)
  );

  logic [3:0] cursor_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cursor_q <= 4'd4;
    end else if (!game_over && (left_p ^ right_p)) begin
      if (right_p) begin
        cursor_q <= (cursor_q == LastCell) ? 4'd0 : cursor_q + 4'd1;
      end else begin
        cursor_q <= (cursor_q == 4'd0) ? LastCell : cursor_q - 4'd1;
      end
    end
  end

  state_e          state_q;
  logic [3:0]      move_pos_q;
  logic            valid_q;
  logic            reject_q;
  logic [DlyW-1:0] dly_q;
  logic [3:0]      scan_q;
  logic            turn_q;
  logic [3:0]      scan_cell;

  assign scan_cell = CPU_PRIO[scan_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      move_pos_q <= 4'd0;
      valid_q    <= 1'b0;
      reject_q   <= 1'b0;
      dly_q      <= '0;
      scan_q     <= 4'd0;
      turn_q     <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      if (game_over) begin
        state_q <= StIdle;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            dly_q   <= '0;
            state_q <= turn ? StCpuWait : StPlayer;
          end
          StPlayer: begin
            // Confirm sees the cursor before any same-cycle left/right update.
            if (confirm_p) begin
              if (cell_empty(board, cursor_q)) begin
                move_pos_q <= cursor_q;
                valid_q    <= 1'b1;
                state_q    <= StIssue;
              end else begin
                reject_q <= 1'b1;
              end
            end
          end
          StCpuWait: begin
            if (dly_q == DlyLast) begin
              scan_q  <= 4'd0;
              state_q <= StCpuScan;
            end else begin
              dly_q <= dly_q + 1'b1;
            end
          end
          StCpuScan: begin
            if (cell_empty(board, scan_cell)) begin
              move_pos_q <= scan_cell;
              valid_q    <= 1'b1;
              state_q    <= StIssue;
            end else if (scan_q == LastCell) begin
              state_q <= StIdle;
            end else begin
              scan_q <= scan_q + 4'd1;
            end
          end
          StIssue: begin
            if (move_ack) begin
              valid_q <= 1'b0;
              turn_q  <= turn;
              state_q <= StSettle;
            end
          end
          StSettle: begin
            // Hold off until the core has handed the turn over.
            if (turn != turn_q) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign cursor     = cursor_q;
  assign move_pos   = move_pos_q;
  assign move_valid = valid_q;
  assign reject     = reject_q;

endmodule

// File: tb/tb_move_selector.sv
// Directed bench for move_selector with short debounce and CPU delay.
module tb_move_selector;
  import ttt_pkg::*;

  localparam logic [17:0] BoardEmpty = 18'h2AAAA;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_confirm = 1'b0;
  logic [17:0] board = BoardEmpty;
  logic        turn = 1'b0;
  logic        game_over = 1'b0;
  logic        move_ack = 1'b0;
  logic [3:0]  cursor;
  logic [3:0]  move_pos;
  logic        move_valid;
  logic        reject;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned rej_cnt = 0;
  int unsigned val_cnt = 0;
  int unsigned idle_cnt = 0;

  always #5 clock = ~clock;

  move_selector #(.DEBOUNCE_CYCLES(4), .CPU_DELAY(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_confirm (btn_confirm),
    .board       (board),
    .turn        (turn),
    .game_over   (game_over),
    .move_ack    (move_ack),
    .cursor      (cursor),
    .move_pos    (move_pos),
    .move_valid  (move_valid),
    .reject      (reject)
  );

  always @(negedge clock) begin
    if (reject) rej_cnt <= rej_cnt + 1;
    if (move_valid) val_cnt <= val_cnt + 1;
    if (dut.state_q == StIdle) idle_cnt <= idle_cnt + 1;
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset(input logic t, input logic [17:0] b);
    reset = 1'b1;
    turn = t;
    board = b;
    game_over = 1'b0;
    move_ack = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // 0 = left, 1 = right, 2 = confirm
  task automatic press(input int which);
    if (which == 0) btn_left = 1'b1;
    else if (which == 1) btn_right = 1'b1;
    else btn_confirm = 1'b1;
    repeat (12) step();
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_confirm = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_reset();
    do_reset(1'b0, BoardEmpty);
    total_cnt++;
    if (cursor !== 4'd4) $display("FAIL reset_cursor: got %0d expected 4", cursor);
    else pass_cnt++;
    total_cnt++;
    if (move_pos !== 4'd0) $display("FAIL reset_move_pos: got %0d expected 0", move_pos);
    else pass_cnt++;
    total_cnt++;
    if (move_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", move_valid);
    else pass_cnt++;
    total_cnt++;
    if (reject !== 1'b0) $display("FAIL reset_reject: got %0b expected 0", reject);
    else pass_cnt++;
    repeat (10) step();
  endtask

  task automatic test_cursor();
    logic [3:0] exp_r [3];
    logic [3:0] exp_l [8];
    exp_r = '{4'd5, 4'd6, 4'd7};
    exp_l = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd8};
    for (int i = 0; i < 3; i++) begin
      press(1);
      total_cnt++;
      if (cursor !== exp_r[i]) $display("FAIL cursor_right%0d: got %0d expected %0d",
                                         i, cursor, exp_r[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 8; i++) begin
      press(0);
      total_cnt++;
      if (cursor !== exp_l[i]) $display("FAIL cursor_left%0d: got %0d expected %0d",
                                         i, cursor, exp_l[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    btn_right = 1'b1;
    repeat (2) step();
    btn_right = 1'b0;
    repeat (15) step();
    total_cnt++;
    if (cursor !== 4'd8) $display("FAIL glitch_cursor: got %0d expected 8", cursor);
    else pass_cnt++;
    repeat (4) press(0);
    total_cnt++;
    if (cursor !== 4'd4) $display("FAIL cursor_back: got %0d expected 4", cursor);
    else pass_cnt++;
  endtask

  task automatic test_player_move();
    int unsigned v0;
    press(2);
    total_cnt++;
    if (move_valid !== 1'b1) $display("FAIL player_valid: got %0b expected 1", move_valid);
    else pass_cnt++;
    total_cnt++;
    if (move_pos !== 4'd4) $display("FAIL player_pos: got %0d expected 4", move_pos);
    else pass_cnt++;
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;
    total_cnt++;
    if (move_valid !== 1'b0) $display("FAIL ack_drop: got %0b expected 0", move_valid);
    else pass_cnt++;
    v0 = val_cnt;
    press(2);
    total_cnt++;
    if (val_cnt != v0) $display("FAIL no_second_issue: got %0d valid cycles expected 0",
                                val_cnt - v0);
    else pass_cnt++;
  endtask

  task automatic test_reject();
    int unsigned r0;
    int unsigned v0;
    do_reset(1'b0, 18'h2A8AA);
    repeat (10) step();
    r0 = rej_cnt;
    v0 = val_cnt;
    press(2);
    total_cnt++;
    if (rej_cnt - r0 != 1) $display("FAIL reject_pulse: got %0d cycles expected 1",
                                    rej_cnt - r0);
    else pass_cnt++;
    total_cnt++;
    if (val_cnt != v0) $display("FAIL reject_no_valid: got %0d valid cycles expected 0",
                                val_cnt - v0);
    else pass_cnt++;
  endtask

  task automatic test_cpu();
    int unsigned n;
    int unsigned v0;
    int unsigned i0;
    // Cells 0 and 4 Player, cell 2 CPU; first empty in priority order is 6.
    do_reset(1'b1, 18'h2A898);
    n = 0;
    while (n < 40 && move_valid !== 1'b1) begin
      step();
      n++;
    end
    total_cnt++;
    if (n != 13) $display("FAIL cpu_latency: got %0d cycles expected 13", n);
    else pass_cnt++;
    total_cnt++;
    if (move_pos !== 4'd6) $display("FAIL cpu_pos: got %0d expected 6", move_pos);
    else pass_cnt++;

    do_reset(1'b1, 18'h00000);
    v0 = val_cnt;
    i0 = idle_cnt;
    repeat (60) step();
    total_cnt++;
    if (val_cnt != v0) $display("FAIL full_no_valid: got %0d valid cycles expected 0",
                                val_cnt - v0);
    else pass_cnt++;
    total_cnt++;
    if (idle_cnt - i0 < 2) $display("FAIL full_back_idle: got %0d idle cycles expected >=2",
                                    idle_cnt - i0);
    else pass_cnt++;
  endtask

  task automatic test_game_over();
    int unsigned v0;
    int unsigned r0;
    do_reset(1'b0, BoardEmpty);
    repeat (10) step();
    press(2);
    total_cnt++;
    if (move_valid !== 1'b1) $display("FAIL go_pre_valid: got %0b expected 1", move_valid);
    else pass_cnt++;
    game_over = 1'b1;
    move_ack = 1'b1;
    step();
    move_ack = 1'b0;
    total_cnt++;
    if (move_valid !== 1'b0) $display("FAIL go_valid_drop: got %0b expected 0", move_valid);
    else pass_cnt++;
    total_cnt++;
    if (dut.state_q !== StIdle) $display("FAIL go_state: got %0d expected %0d",
                                         dut.state_q, StIdle);
    else pass_cnt++;
    v0 = val_cnt;
    r0 = rej_cnt;
    press(2);
    press(1);
    total_cnt++;
    if (val_cnt != v0) $display("FAIL go_confirm_ignored: got %0d valid cycles expected 0",
                                val_cnt - v0);
    else pass_cnt++;
    total_cnt++;
    if (rej_cnt != r0) $display("FAIL go_no_reject: got %0d expected 0", rej_cnt - r0);
    else pass_cnt++;
    total_cnt++;
    if (cursor !== 4'd4) $display("FAIL go_cursor_frozen: got %0d expected 4", cursor);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_glitch();
    test_player_move();
    test_reject();
    test_cpu();
    test_game_over();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
